// File: rtl/add_rsp_pkg.sv
// Shared types and constants for the add_responder slice.
// Occupancy encoding is visible on the occ_state port: EMPTY=0, PARTIAL=1, FULL=2.
package add_rsp_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/add_rsp_fifo.sv
// Response FIFO: storage, wrapping pointers and a separate occupancy count.
// Latency: a pushed entry is readable at rdata from the next cycle; rdata is the combinational head.
// Backpressure: pushes while full are dropped unless a pop happens in the same cycle.
module add_rsp_fifo #(
    parameter  int W     = 4,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // When full, the slot being written is the one being popped this cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/add_responder.sv
// Operand/sum responder: accepts (x,y) requests and returns z=x+y in order; ADD_RSP_STATS_EN adds stat counters.
// Latency: a request accepted at edge N presents its sum from cycle N+1 when the FIFO was empty.
// Backpressure: req_ready drops when the FIFO is full unless a response pops in the same cycle.
module add_responder
    import add_rsp_pkg::*;
#(
    parameter  int OP_W  = 3,
    parameter  int DEPTH = 2,
    localparam int RES_W = OP_W + 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_x,
    input  logic [OP_W-1:0]  req_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_z,
    output occ_e             occ_state
`ifdef ADD_RSP_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_txn,
    output logic [STAT_W-1:0] stat_carry
`endif
);

    logic             rdy_q;
    logic             push;
    logic             pop;
    logic [RES_W-1:0] sum;
    logic [RES_W-1:0] head;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             full;
    logic             empty;
    occ_e             occ_q;
    occ_e             occ_nxt;

    // Holds req_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    assign rsp_valid = !empty;
    assign pop       = rsp_valid && rsp_ready;
    assign req_ready = rdy_q && (!full || pop);
    assign push      = req_valid && req_ready;
    assign sum       = {1'b0, req_x} + {1'b0, req_y};
    assign rsp_z     = empty ? '0 : head;

    add_rsp_fifo #(
        .W     (RES_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (sum),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        count_nxt = count;
        if (push && !pop)      count_nxt = count + CW'(1);
        else if (pop && !push) count_nxt = count - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ_q <= OCC_EMPTY;
        else        occ_q <= occ_nxt;
    end

    always_comb begin
        occ_nxt = occ_q;
        unique case (occ_q)
            OCC_EMPTY:   if (push && !pop) occ_nxt = OCC_PARTIAL;
            OCC_PARTIAL: begin
                if (count_nxt == CW'(DEPTH)) occ_nxt = OCC_FULL;
                else if (count_nxt == '0)    occ_nxt = OCC_EMPTY;
            end
            OCC_FULL:    if (pop && !push) occ_nxt = OCC_PARTIAL;
            default:     occ_nxt = OCC_EMPTY;
        endcase
    end

    always_comb begin
        occ_state = occ_q;
    end

`ifdef ADD_RSP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_txn   <= '0;
            stat_carry <= '0;
        end else if (pop) begin
            if (stat_txn != '1) stat_txn <= stat_txn + STAT_W'(1);
            if (rsp_z[RES_W-1] && (stat_carry != '1)) stat_carry <= stat_carry + STAT_W'(1);
        end
    end
`endif

endmodule
